// File: rtl/image_bbox_detect.sv
`default_nettype none
// image_bbox_detect: per-frame bounding box and foreground pixel count of a binary video stream.
// Rev 1.0 - initial release
module image_bbox_detect #(
  parameter int XW      = 12,
  parameter int YW      = 12,
  parameter int CW      = 20,
  parameter int MIN_PIX = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hsync_i,
  input  logic          vsync_i,
  input  logic          de_i,
  input  logic [7:0]    data_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o,
  output logic [7:0]    data_o,
  output logic          box_valid,
  output logic          box_found,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max,
  output logic [CW-1:0] pix_cnt
);

  localparam logic [31:0] c_MIN_PIX = MIN_PIX;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    RUN     = 2'd1,
    REPORT  = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_vs_d;
  logic          r_de_d;
  logic [XW-1:0] r_x_cnt;
  logic [YW-1:0] r_y_cnt;
  logic          r_any;
  logic [XW-1:0] r_acc_xmin;
  logic [XW-1:0] r_acc_xmax;
  logic [YW-1:0] r_acc_ymin;
  logic [YW-1:0] r_acc_ymax;
  logic [CW-1:0] r_fg_cnt;

  logic w_vs_rise;
  logic w_line_end;
  logic w_fg;
  logic w_found;

  assign w_vs_rise  = vsync_i & ~r_vs_d;
  assign w_line_end = r_de_d & ~de_i;
  assign w_fg       = de_i & (data_i != 8'h00);
  assign w_found    = (32'(r_fg_cnt) >= c_MIN_PIX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
      de_o    <= 1'b0;
      data_o  <= 8'h00;
    end else begin
      hsync_o <= hsync_i;
      vsync_o <= vsync_i;
      de_o    <= de_i;
      data_o  <= data_i;
    end
  end

  // Saturating pixel position counters; the frame-boundary clear beats a line end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vs_d  <= 1'b0;
      r_de_d  <= 1'b0;
      r_x_cnt <= '0;
      r_y_cnt <= '0;
    end else begin
      r_vs_d <= vsync_i;
      r_de_d <= de_i;
      if (de_i) begin
        if (r_x_cnt != '1) r_x_cnt <= r_x_cnt + XW'(1);
      end else if (w_line_end) begin
        r_x_cnt <= '0;
      end
      if (w_vs_rise) r_y_cnt <= '0;
      else if (w_line_end && (r_y_cnt != '1)) r_y_cnt <= r_y_cnt + YW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= WAIT_VS;
      r_any      <= 1'b0;
      r_acc_xmin <= '0;
      r_acc_xmax <= '0;
      r_acc_ymin <= '0;
      r_acc_ymax <= '0;
      r_fg_cnt   <= '0;
      box_valid  <= 1'b0;
      box_found  <= 1'b0;
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
      pix_cnt    <= '0;
    end else begin
      box_valid <= 1'b0;
      case (r_state)
        WAIT_VS: begin
          if (w_vs_rise) begin
            r_state    <= RUN;
            r_any      <= 1'b0;
            r_acc_xmin <= '0;
            r_acc_xmax <= '0;
            r_acc_ymin <= '0;
            r_acc_ymax <= '0;
            r_fg_cnt   <= '0;
          end
        end
        RUN: begin
          if (w_vs_rise) begin
            // A pixel coinciding with the frame edge is dropped: it belongs to neither frame.
            r_state    <= REPORT;
            box_valid  <= 1'b1;
            box_found  <= w_found;
            pix_cnt    <= r_fg_cnt;
            x_min      <= w_found ? r_acc_xmin : '0;
            x_max      <= w_found ? r_acc_xmax : '0;
            y_min      <= w_found ? r_acc_ymin : '0;
            y_max      <= w_found ? r_acc_ymax : '0;
            r_any      <= 1'b0;
            r_acc_xmin <= '0;
            r_acc_xmax <= '0;
            r_acc_ymin <= '0;
            r_acc_ymax <= '0;
            r_fg_cnt   <= '0;
          end else if (w_fg) begin
            r_any <= 1'b1;
            if (!r_any) begin
              r_acc_xmin <= r_x_cnt;
              r_acc_xmax <= r_x_cnt;
              r_acc_ymin <= r_y_cnt;
              r_acc_ymax <= r_y_cnt;
            end else begin
              if (r_x_cnt < r_acc_xmin) r_acc_xmin <= r_x_cnt;
              if (r_x_cnt > r_acc_xmax) r_acc_xmax <= r_x_cnt;
              if (r_y_cnt < r_acc_ymin) r_acc_ymin <= r_y_cnt;
              if (r_y_cnt > r_acc_ymax) r_acc_ymax <= r_y_cnt;
            end
            if (r_fg_cnt != '1) r_fg_cnt <= r_fg_cnt + CW'(1);
          end
        end
        REPORT: begin
          r_state    <= RUN;
          r_any      <= 1'b0;
          r_acc_xmin <= '0;
          r_acc_xmax <= '0;
          r_acc_ymin <= '0;
          r_acc_ymax <= '0;
          r_fg_cnt   <= '0;
        end
        default: r_state <= WAIT_VS;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_image_bbox_detect.sv
`default_nettype none
// tb_image_bbox_detect: table vectors, corner sequences and random frames against a behavioural model.
// Rev 1.0 - initial release
module tb_image_bbox_detect;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hsync_i = 1'b0, vsync_i = 1'b0, de_i = 1'b0;
  logic [7:0] data_i = 8'h00;

  // Instance A: MIN_PIX=1, default widths. Instance B: MIN_PIX=4, 4-bit count to reach saturation.
  logic a_hs, a_vs, a_de, a_valid, a_found;
  logic [7:0] a_data;
  logic [11:0] a_xmin, a_xmax, a_ymin, a_ymax;
  logic [19:0] a_pix;
  logic b_hs, b_vs, b_de, b_valid, b_found;
  logic [7:0] b_data;
  logic [11:0] b_xmin, b_xmax, b_ymin, b_ymax;
  logic [3:0] b_pix;

  always #5 clk = ~clk;

  image_bbox_detect #(.XW(12), .YW(12), .CW(20), .MIN_PIX(1)) dut_a (
    .clk(clk), .rst(rst), .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i), .data_i(data_i),
    .hsync_o(a_hs), .vsync_o(a_vs), .de_o(a_de), .data_o(a_data),
    .box_valid(a_valid), .box_found(a_found), .x_min(a_xmin), .x_max(a_xmax),
    .y_min(a_ymin), .y_max(a_ymax), .pix_cnt(a_pix));

  image_bbox_detect #(.XW(12), .YW(12), .CW(4), .MIN_PIX(4)) dut_b (
    .clk(clk), .rst(rst), .hsync_i(hsync_i), .vsync_i(vsync_i), .de_i(de_i), .data_i(data_i),
    .hsync_o(b_hs), .vsync_o(b_vs), .de_o(b_de), .data_o(b_data),
    .box_valid(b_valid), .box_found(b_found), .x_min(b_xmin), .x_max(b_xmax),
    .y_min(b_ymin), .y_max(b_ymax), .pix_cnt(b_pix));

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit m_vsd, m_ded, m_armed, m_skip, m_any;
  int m_x, m_y, m_cnt, m_xmin, m_xmax, m_ymin, m_ymax;
  bit e_valid;
  int e_cnt, e_xmin, e_xmax, e_ymin, e_ymax;
  logic p_hs, p_vs, p_de;
  logic [7:0] p_data;

  bit fgmap [0:15][0:15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_vsd = 0; m_ded = 0; m_armed = 0; m_skip = 0; m_any = 0;
    m_x = 0; m_y = 0; m_cnt = 0; m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
    e_valid = 0; e_cnt = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
    p_hs = 0; p_vs = 0; p_de = 0; p_data = 8'h00;
  endtask

  task automatic model_step(input logic hs, input logic vs, input logic de, input logic [7:0] d);
    bit vr, le, fg, running;
    vr = vs && !m_vsd;
    le = m_ded && !de;
    fg = de && (d != 8'h00);
    running = m_armed && !m_skip;
    e_valid = 0;
    if (vr && running) begin
      e_valid = 1;
      e_cnt = m_cnt;
      e_xmin = m_xmin; e_xmax = m_xmax; e_ymin = m_ymin; e_ymax = m_ymax;
    end
    if (running && !vr && fg) begin
      if (!m_any) begin
        m_xmin = m_x; m_xmax = m_x; m_ymin = m_y; m_ymax = m_y;
      end else begin
        if (m_x < m_xmin) m_xmin = m_x;
        if (m_x > m_xmax) m_xmax = m_x;
        if (m_y < m_ymin) m_ymin = m_y;
        if (m_y > m_ymax) m_ymax = m_y;
      end
      m_any = 1;
      m_cnt++;
    end
    if (vr || m_skip) begin
      m_any = 0; m_cnt = 0; m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
    end
    m_skip = e_valid;
    m_armed = m_armed || vr;
    if (de) m_x = (m_x < 4095) ? m_x + 1 : 4095;
    else if (le) m_x = 0;
    if (vr) m_y = 0;
    else if (le) m_y = (m_y < 4095) ? m_y + 1 : 4095;
    m_vsd = vs; m_ded = de;
    p_hs = hs; p_vs = vs; p_de = de; p_data = d;
  endtask

  task automatic check_all();
    bit fa, fb;
    fa = (e_cnt >= 1);
    fb = (e_cnt >= 4);
    chk("hsync_o", a_hs, p_hs);   chk("vsync_o", a_vs, p_vs);
    chk("de_o", a_de, p_de);      chk("data_o", a_data, p_data);
    chk("b_data_o", {b_hs, b_vs, b_de, b_data}, {p_hs, p_vs, p_de, p_data});
    chk("valid_a", a_valid, e_valid);
    chk("valid_b", b_valid, e_valid);
    chk("found_a", a_found, fa);
    chk("found_b", b_found, fb);
    chk("pix_a", a_pix, (e_cnt > 20'hFFFFF) ? 20'hFFFFF : e_cnt);
    chk("pix_b", b_pix, (e_cnt > 15) ? 15 : e_cnt);
    chk("box_a", {a_xmin, a_xmax}, fa ? {e_xmin[11:0], e_xmax[11:0]} : 24'h0);
    chk("boy_a", {a_ymin, a_ymax}, fa ? {e_ymin[11:0], e_ymax[11:0]} : 24'h0);
    chk("box_b", {b_xmin, b_xmax}, fb ? {e_xmin[11:0], e_xmax[11:0]} : 24'h0);
    chk("boy_b", {b_ymin, b_ymax}, fb ? {e_ymin[11:0], e_ymax[11:0]} : 24'h0);
  endtask

  task automatic cyc(input logic hs, input logic vs, input logic de, input logic [7:0] d);
    hsync_i = hs; vsync_i = vs; de_i = de; data_i = d;
    model_step(hs, vs, de, d);
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic lines(input int w, input int h, input int y0, input int blank);
    for (int y = y0; y < h; y++) begin
      for (int x = 0; x < w; x++) cyc(1'b0, 1'b0, 1'b1, fgmap[y][x] ? 8'hFF : 8'h00);
      for (int b = 0; b < blank; b++) cyc(1'b1, 1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic vs_rest(input int len);
    for (int i = 1; i < len; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic clear_map();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) fgmap[y][x] = 0;
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk(nm, {a_valid, a_found, a_xmin, a_xmax, a_ymin, a_ymax, a_pix}, '0);
    chk({nm, "_pt"}, {a_hs, a_vs, a_de, a_data}, '0);
  endtask

  typedef struct {
    int n;          // -1 means every pixel is foreground
    int px [5];
    int py [5];
    int cnt_a, cnt_b, found_a, found_b, xmin, xmax, ymin, ymax;
  } vec_t;

  vec_t vt [6];

  initial begin
    vt[0] = '{0, '{0,0,0,0,0}, '{0,0,0,0,0}, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[1] = '{3, '{2,5,3,0,0}, '{1,1,3,0,0}, 3, 3, 1, 0, 2, 5, 1, 3};
    vt[2] = '{1, '{7,0,0,0,0}, '{3,0,0,0,0}, 1, 1, 1, 0, 7, 7, 3, 3};
    vt[3] = '{3, '{0,7,4,0,0}, '{0,3,2,0,0}, 3, 3, 1, 0, 0, 7, 0, 3};
    vt[4] = '{5, '{1,6,3,2,5}, '{2,0,1,3,2}, 5, 5, 1, 1, 1, 6, 0, 3};
    vt[5] = '{-1, '{0,0,0,0,0}, '{0,0,0,0,0}, 32, 15, 1, 1, 0, 7, 0, 3};

    model_reset();
    clear_map();
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset_state");
    rst = 1'b0;

    // Partial frame after reset is discarded: first edge gives no report.
    lines(8, 4, 0, 2);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("first_edge_no_report", a_valid, 1'b0);
    vs_rest(2);

    for (int i = 0; i < 6; i++) begin
      clear_map();
      if (vt[i].n < 0) begin
        for (int y = 0; y < 4; y++)
          for (int x = 0; x < 8; x++) fgmap[y][x] = 1;
      end else begin
        for (int k = 0; k < vt[i].n; k++) fgmap[vt[i].py[k]][vt[i].px[k]] = 1;
      end
      lines(8, 4, 0, 2);
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk("tbl_valid", {a_valid, b_valid}, 2'b11);
      chk("tbl_pix_a", a_pix, vt[i].cnt_a);
      chk("tbl_pix_b", b_pix, vt[i].cnt_b);
      chk("tbl_found", {a_found, b_found}, {vt[i].found_a[0], vt[i].found_b[0]});
      chk("tbl_box_a", {a_xmin, a_xmax, a_ymin, a_ymax},
          vt[i].found_a != 0 ? {vt[i].xmin[11:0], vt[i].xmax[11:0], vt[i].ymin[11:0], vt[i].ymax[11:0]} : 48'h0);
      chk("tbl_box_b", {b_xmin, b_xmax, b_ymin, b_ymax},
          vt[i].found_b != 0 ? {vt[i].xmin[11:0], vt[i].xmax[11:0], vt[i].ymin[11:0], vt[i].ymax[11:0]} : 48'h0);
      vs_rest(1 + i % 3);
    end

    // Foreground pixel on the vs_rise cycle belongs to neither frame.
    clear_map();
    fgmap[0][1] = 1;
    lines(8, 4, 0, 2);
    cyc(1'b0, 1'b1, 1'b1, 8'hFF);
    chk("edge_px_close_cnt", a_pix, 20'd1);
    chk("edge_px_close_box", {a_xmin, a_xmax}, {12'd1, 12'd1});
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("edge_px_pulse_len", a_valid, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    clear_map();
    lines(8, 4, 0, 2);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("edge_px_new_frame", {a_valid, a_found, a_pix}, {1'b1, 1'b0, 20'd0});
    vs_rest(2);

    // Reset mid-frame after a non-zero report.
    fgmap[2][4] = 1;
    lines(8, 4, 0, 2);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    vs_rest(2);
    lines(8, 2, 0, 2);
    hsync_i = 1'b0; vsync_i = 1'b0; de_i = 1'b0; data_i = 8'h00;
    rst = 1'b1;
    #1;
    chk_zero_outputs("async_reset");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    lines(8, 4, 2, 2);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("post_reset_no_report", a_valid, 1'b0);
    vs_rest(2);
    lines(8, 4, 0, 2);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("post_reset_report", {a_valid, a_found, a_pix, a_xmin, a_ymin},
        {1'b1, 1'b1, 20'd1, 12'd4, 12'd2});
    vs_rest(2);

    // Randomised frames of varying geometry and density.
    for (int f = 0; f < 40; f++) begin
      int w, h, dens;
      w = $urandom_range(2, 12);
      h = $urandom_range(1, 6);
      dens = $urandom_range(0, 100);
      for (int y = 0; y < 16; y++)
        for (int x = 0; x < 16; x++) fgmap[y][x] = ($urandom_range(0, 99) < dens);
      lines(w, h, 0, $urandom_range(1, 3));
      vs_rest($urandom_range(1, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
